// File: rtl/cpu_icache_pkg.sv
// Shared types and address-geometry helpers for the instruction cache.
// Optional feature macro: ICACHE_PERF_EN (hit/miss counters).
package cpu_icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        REPLAY
    } state_e;

    function automatic int off_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int aw, input int lines,
                                    input int words);
        return aw - idx_bits(lines) - off_bits(words);
    endfunction

    // A one-word line still needs a 1-bit slot select.
    function automatic int slot_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic logic [63:0] line_base(input logic [63:0] addr,
                                              input int words);
        return addr & ~((64'(words) << 2) - 64'd1);
    endfunction

endpackage

// File: rtl/cpu_icache_if.sv
// Memory-bus bundle between the cache (master) and the shared bus (slave).
// Optional feature macro: ICACHE_PERF_EN (not used here).
interface cpu_icache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_request;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_rdata;
    logic                  mem_busy;
    logic                  mem_valid;

    modport master (
        output mem_request, mem_address,
        input  mem_rdata, mem_busy, mem_valid
    );

    modport slave (
        input  mem_request, mem_address,
        output mem_rdata, mem_busy, mem_valid
    );
endinterface

// File: rtl/cpu_icache_refill.sv
// Line refill sequencer: independent issue and receive counters on the bus.
// Optional feature macro: ICACHE_PERF_EN (not used here).
module cpu_icache_refill
    import cpu_icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    localparam int SW            = slot_bits(WORDS_PER_LINE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  active,
    input  logic [ADDR_WIDTH-1:0] base,
    cpu_icache_if.master          mem,
    output logic                  wr_en,
    output logic [SW-1:0]         wr_slot,
    output logic                  done
);
    localparam int CW = $clog2(WORDS_PER_LINE) + 1;

    logic [CW-1:0] iss_q, iss_d;
    logic [CW-1:0] rcv_q, rcv_d;

    // Bus handshake, word strobes and counter advance; idle clears counters.
    always_comb begin
        iss_d           = iss_q;
        rcv_d           = rcv_q;
        mem.mem_request = active && (iss_q < CW'(WORDS_PER_LINE));
        mem.mem_address = base + (ADDR_WIDTH'(iss_q) << 2);
        wr_en           = active && mem.mem_valid
                          && (rcv_q < CW'(WORDS_PER_LINE));
        wr_slot         = SW'(rcv_q);
        done            = wr_en && (rcv_q == CW'(WORDS_PER_LINE - 1));
        if (!active) begin
            iss_d = '0;
            rcv_d = '0;
        end else begin
            if (mem.mem_request && !mem.mem_busy) iss_d = iss_q + 1'b1;
            if (wr_en)                            rcv_d = rcv_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            iss_q <= '0;
            rcv_q <= '0;
        end else begin
            iss_q <= iss_d;
            rcv_q <= rcv_d;
        end
    end
endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache with one-cycle pipelined hits.
// Optional feature macro: ICACHE_PERF_EN (hit/miss counters).
module cpu_icache
    import cpu_icache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  flush,
    output logic [31:0]           p2_instr,
    output logic [ADDR_WIDTH-1:0] p2_addr,
    output logic                  p2_ack,
    output logic                  busy,
    cpu_icache_if.master          mem,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int OFW = off_bits(WORDS_PER_LINE);
    localparam int IW  = idx_bits(LINES);
    localparam int TW  = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE);
    localparam int SW  = slot_bits(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] WMASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);

    logic [31:0]   data_mem [LINES][WORDS_PER_LINE];
    logic [TW-1:0] tag_mem  [LINES];

    state_e                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  flushed_q, flushed_d;
    logic                  p2_ack_q, p2_ack_d;
    logic [31:0]           p2_instr_q, p2_instr_d;
    logic [ADDR_WIDTH-1:0] p2_addr_q, p2_addr_d;
    logic                  busy_q, busy_d;
    logic                  hit, miss, tag_we;

    logic [ADDR_WIDTH-1:0] p1_a;
    logic [IW-1:0]         p1_idx, m_idx;
    logic [TW-1:0]         p1_tag, m_tag;
    logic [SW-1:0]         p1_word, m_word;
    logic                  unused_lsb;

    logic                  rf_we, rf_done;
    logic [SW-1:0]         rf_slot;
    logic [ADDR_WIDTH-1:0] rf_base;

    assign unused_lsb = ^p1_addr[1:0];
    assign p1_a    = {p1_addr[ADDR_WIDTH-1:2], 2'b00};
    assign p1_idx  = IW'(p1_a >> OFW);
    assign p1_tag  = p1_a[ADDR_WIDTH-1 -: TW];
    assign p1_word = SW'((p1_a >> 2) & WMASK);
    assign m_idx   = IW'(miss_addr_q >> OFW);
    assign m_tag   = miss_addr_q[ADDR_WIDTH-1 -: TW];
    assign m_word  = SW'((miss_addr_q >> 2) & WMASK);
    assign rf_base = ADDR_WIDTH'(line_base(64'(miss_addr_q), WORDS_PER_LINE));

    cpu_icache_refill #(
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_refill (
        .clock  (clock),
        .reset  (reset),
        .active (state_q == REFILL),
        .base   (rf_base),
        .mem    (mem),
        .wr_en  (rf_we),
        .wr_slot(rf_slot),
        .done   (rf_done)
    );

    // Lookup, miss entry, refill completion and replay.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        flushed_d   = flushed_q;
        p2_ack_d    = 1'b0;
        p2_instr_d  = p2_instr_q;
        p2_addr_d   = p2_addr_q;
        busy_d      = busy_q;
        hit         = 1'b0;
        miss        = 1'b0;
        tag_we      = 1'b0;
        if (flush) valid_d = '0;
        unique case (state_q)
            IDLE: begin
                if (p1_req) begin
                    if (!flush && valid_q[p1_idx]
                        && (tag_mem[p1_idx] == p1_tag)) begin
                        hit        = 1'b1;
                        p2_ack_d   = 1'b1;
                        p2_instr_d = data_mem[p1_idx][p1_word];
                        p2_addr_d  = p1_a;
                    end else begin
                        miss        = 1'b1;
                        miss_addr_d = p1_a;
                        flushed_d   = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = REFILL;
                    end
                end
            end
            REFILL: begin
                if (flush) flushed_d = 1'b1;
                if (rf_done) begin
                    tag_we         = 1'b1;
                    valid_d[m_idx] = !(flushed_q || flush);
                    state_d        = REPLAY;
                end
            end
            REPLAY: begin
                p2_ack_d   = 1'b1;
                p2_instr_d = data_mem[m_idx][m_word];
                p2_addr_d  = miss_addr_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            flushed_q   <= 1'b0;
            p2_ack_q    <= 1'b0;
            p2_instr_q  <= '0;
            p2_addr_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            flushed_q   <= flushed_d;
            p2_ack_q    <= p2_ack_d;
            p2_instr_q  <= p2_instr_d;
            p2_addr_q   <= p2_addr_d;
            busy_q      <= busy_d;
        end
    end

    // Data and tag storage; no reset, validity lives in valid_q.
    always_ff @(posedge clock) begin
        if (rf_we)  data_mem[m_idx][rf_slot] <= mem.mem_rdata;
        if (tag_we) tag_mem[m_idx]           <= m_tag;
    end

    assign p2_ack   = p2_ack_q;
    assign p2_instr = p2_instr_q;
    assign p2_addr  = p2_addr_q;
    assign busy     = busy_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Hit/miss event counting; both wrap naturally.
    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit};
        miss_cnt_d = miss_cnt_q + {31'd0, miss};
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = hit ^ miss;
    assign hit_count   = '0;
    assign miss_count  = '0;
`endif
endmodule

// File: tb/tb_cpu_icache.sv
// Directed self-checking bench for cpu_icache (LINES=64, WORDS_PER_LINE=4).
// Memory word at byte address A is 32'hDEAD0000 ^ A.
module tb_cpu_icache;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        p1_req  = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] p1_addr = '0;
    logic [31:0] p2_instr, p2_addr, hit_count, miss_count;
    logic        p2_ack, busy;

    cpu_icache_if #(.ADDR_WIDTH(32)) mem ();

    cpu_icache #(
        .LINES(64), .WORDS_PER_LINE(4), .ADDR_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .p1_req(p1_req), .p1_addr(p1_addr),
        .flush(flush), .p2_instr(p2_instr), .p2_addr(p2_addr),
        .p2_ack(p2_ack), .busy(busy), .mem(mem),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int h, input int m);
`ifdef ICACHE_PERF_EN
        chk({nm, "_hits"}, hit_count, 32'(h));
        chk({nm, "_misses"}, miss_count, 32'(m));
`else
        chk({nm, "_hits_tied"}, hit_count, 32'd0);
        chk({nm, "_misses_tied"}, miss_count, 32'd0);
        if (h < 0 || m < 0) $display("negative count expectation");
`endif
    endtask

    // ---------------- memory model ----------------
    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    int          stall_at = -1, stall_left = 0, stall_busy = 0, stall_bad = 0;
    logic [31:0] stall_addr = '0;
    int          inject = 0, drop = 0;
    int          edge_cnt = 0, last_rsp = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hDEAD0000 ^ a;
    endfunction

    initial begin
        mem.mem_busy  = 1'b0;
        mem.mem_valid = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (drop != 0) begin
                pend.delete();
                drop = 0;
            end
            if (inject > 0) begin
                mem.mem_valid = 1'b1;
                mem.mem_rdata = 32'hBAD0BAD0;
                inject--;
            end else if (pend.size() > 0) begin
                mem.mem_valid = 1'b1;
                mem.mem_rdata = mem_word(pend.pop_front());
                last_rsp      = edge_cnt + 1;
            end else begin
                mem.mem_valid = 1'b0;
                mem.mem_rdata = '0;
            end
            if (mem.mem_request && acc_log.size() == stall_at
                && stall_left > 0) begin
                mem.mem_busy = 1'b1;
                stall_left--;
                stall_busy++;
                if (mem.mem_address !== stall_addr) stall_bad++;
            end else begin
                mem.mem_busy = 1'b0;
            end
            if (mem.mem_request && !mem.mem_busy) begin
                pend.push_back(mem.mem_address);
                acc_log.push_back(mem.mem_address);
            end
        end
    end

    // ---------------- fetch sequence ----------------
    task automatic do_fetch(input logic [31:0] a, input bit is_miss,
                            input logic [31:0] ins, input string nm,
                            input bit flush_mid);
        int n;
        acc_log.delete();
        p1_req  = 1'b1;
        p1_addr = a;
        @(negedge clock);
        if (!is_miss) begin
            chk({nm, "_ack"}, {31'd0, p2_ack}, 32'd1);
            chk({nm, "_instr"}, p2_instr, ins);
            chk({nm, "_addr"}, p2_addr, a);
        end else begin
            chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            chk({nm, "_noack"}, {31'd0, p2_ack}, 32'd0);
            p1_req  = 1'b0;
            p1_addr = 32'hFFFF_FFF0;
            if (flush_mid) begin
                @(negedge clock);
                flush = 1'b1;
                @(negedge clock);
                flush = 1'b0;
            end
            n = 0;
            while (!p2_ack && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (!p2_ack) begin
                chk({nm, "_timeout"}, 32'd0, 32'd1);
            end else begin
                chk({nm, "_instr"}, p2_instr, ins);
                chk({nm, "_addr"}, p2_addr, a);
                chk({nm, "_lat"}, 32'(edge_cnt), 32'(last_rsp + 1));
                chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
                chk({nm, "_req_done"}, {31'd0, mem.mem_request}, 32'd0);
                chk({nm, "_accepts"}, 32'(acc_log.size()), 32'd4);
                if (acc_log.size() == 4)
                    for (int i = 0; i < 4; i++)
                        chk({nm, "_rdaddr"}, acc_log[i],
                            (a & ~32'hF) + 32'(4 * i));
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] instr;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h0000_0100, 1'b1, 32'hDEAD_0100, 0, 1};
        vt[1] = '{32'h0000_0104, 1'b0, 32'hDEAD_0104, 1, 1};
        vt[2] = '{32'h0000_0108, 1'b0, 32'hDEAD_0108, 2, 1};
        vt[3] = '{32'h0000_010C, 1'b0, 32'hDEAD_010C, 3, 1};
        vt[4] = '{32'h0000_1100, 1'b1, 32'hDEAD_1100, 3, 2};
        vt[5] = '{32'h0000_0100, 1'b1, 32'hDEAD_0100, 3, 3};
        vt[6] = '{32'h0000_0104, 1'b0, 32'hDEAD_0104, 4, 3};
        vt[7] = '{32'h0000_0108, 1'b0, 32'hDEAD_0108, 5, 3};

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst_ack", {31'd0, p2_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem.mem_request}, 32'd0);
        chk("rst_instr", p2_instr, 32'd0);
        chk("rst_addr", p2_addr, 32'd0);
        chk_cnt("rst", 0, 0);
        reset = 1'b1;
        @(negedge clock);

        // Cold miss, pipelined hits, conflict eviction.
        for (int i = 0; i < 8; i++) begin
            do_fetch(vt[i].addr, vt[i].miss, vt[i].instr, $sformatf("v%0d", i), 1'b0);
            chk_cnt($sformatf("v%0d", i), vt[i].hits, vt[i].misses);
        end
        p1_req = 1'b0;
        @(negedge clock);
        chk("idle_noack", {31'd0, p2_ack}, 32'd0);

        // Bus stall on the second request.
        stall_at   = 1;
        stall_left = 5;
        stall_addr = 32'h0000_2004;
        do_fetch(32'h0000_2000, 1'b1, 32'hDEAD_2000, "stall", 1'b0);
        chk("stall_cycles", 32'(stall_busy), 32'd5);
        chk("stall_addr_moved", 32'(stall_bad), 32'd0);
        do_fetch(32'h0000_200C, 1'b0, 32'hDEAD_200C, "stall_hit", 1'b0);
        chk_cnt("stall", 6, 4);
        p1_req = 1'b0;
        @(negedge clock);

        // Flush in idle, then refetch misses.
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        do_fetch(32'h0000_0100, 1'b1, 32'hDEAD_0100, "flush_idle", 1'b0);
        chk_cnt("flush_idle", 6, 5);

        // Flush during refill: replay delivers, line stays invalid.
        do_fetch(32'h0000_0300, 1'b1, 32'hDEAD_0300, "flush_mid", 1'b1);
        do_fetch(32'h0000_0300, 1'b1, 32'hDEAD_0300, "flush_refetch", 1'b0);
        chk_cnt("flush_mid", 6, 7);
        p1_req = 1'b0;
        @(negedge clock);

        // Reset mid-refill with stale responses afterwards.
        acc_log.delete();
        p1_req  = 1'b1;
        p1_addr = 32'h0000_0100;
        @(negedge clock);
        p1_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        inject = 2;
        drop   = 1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_req", {31'd0, mem.mem_request}, 32'd0);
        chk("mrst_ack", {31'd0, p2_ack}, 32'd0);
        chk_cnt("mrst", 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stale_ignored", {30'd0, p2_ack, busy}, 32'd0);
        end
        do_fetch(32'h0000_0100, 1'b1, 32'hDEAD_0100, "post_rst", 1'b0);
        chk_cnt("post_rst", 0, 1);
        p1_req = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_icache.md
Name: cpu_icache

Overview:
- Parametrised, direct-mapped, read-only instruction cache between the cpu_pc fetch stage and the shared memory bus.
- CPU side follows the pipeline stage naming: address in p1, instruction and ack out in p2.
- Hits return in one cycle, pipelined at one fetch per cycle.
- Misses run a line refill over the request/busy/valid bus, then replay the fetch.

Parameters:
- LINES, 64, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 1.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- p1_req  in  1  fetch request this cycle.
- p1_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate the whole cache (single-cycle pulse).
- p2_instr  out  32  instruction for p2_addr.
- p2_addr  out  ADDR_WIDTH  address that p2_instr belongs to.
- p2_ack  out  1  p2_instr valid this cycle.
- busy  out  1  miss in progress; CPU must stall.
- mem_request  out  1  memory read request.
- mem_address  out  ADDR_WIDTH  word-aligned read address.
- mem_rdata  in  32  read data.
- mem_busy  in  1  bus cannot accept a request.
- mem_valid  in  1  mem_rdata valid; responses return in issue order.
- hit_count  out  32  hit counter (optional feature).
- miss_count  out  32  miss counter (optional feature).

Behaviour:
- Address split:
  - offset = log2(WORDS_PER_LINE) + 2 bits.
  - index = log2(LINES) bits.
  - tag = the remaining upper bits.
- Storage: data array LINES*WORDS_PER_LINE x 32, tag array, and a valid bit per line. Valid bits are in flip-flops so they can be cleared in one cycle.
- Reset (reset==0 at a clock edge):
  - all valid bits cleared, state IDLE;
  - p2_ack, busy and mem_request = 0;
  - p2_instr and p2_addr = 0;
  - counters = 0.
- IDLE, p1_req=1:
  - Hit (valid && tag match) registered at edge N: p2_ack=1, p2_instr and p2_addr updated at edge N+1.
  - Back-to-back hits give continuous p2_ack.
  - p1_req=0: p2_ack=0 next cycle.
- Miss:
  - Latch the miss address; p2_ack=0; busy=1 from the next cycle; go to REFILL.
  - p1_addr and p1_req are ignored until REPLAY completes.
- REFILL:
  - Issue WORDS_PER_LINE reads at line base + 0, 4, 8, and so on, in order.
  - mem_request and mem_address stay stable while mem_busy=1; a request is accepted on a cycle with mem_request && !mem_busy.
  - The issue counter advances on each accept.
  - mem_request drops the cycle after the last accept.
  - Each mem_valid writes mem_rdata to the next word slot. The receive counter is independent of the issue counter, so responses can overlap issues.
  - After the last response: write the tag, set the line's valid bit, go to REPLAY.
- REPLAY:
  - Next edge: p2_ack=1 with the latched address and its word; busy=0; return to IDLE.
  - The CPU presents its next fetch in that cycle.
- Conflict: the new line overwrites the old line at the same index; there is no write-back (read-only).
- Flush:
  - In IDLE: all valid bits clear at the next edge.
  - A fetch on the same cycle as flush is treated as a miss.
  - During REFILL: the refill completes and replays, but the line is NOT marked valid.
- mem_valid while in IDLE: discarded (covers reset during a refill). Reset during REFILL abandons it immediately.
- Counters wrap at 2^32.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - hit_count increments on each IDLE hit.
  - miss_count increments on each miss entry; REPLAY is not counted as a hit.
  - Both are cleared by reset.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Package cpu_icache_pkg:
  - state enum (IDLE, REFILL, REPLAY);
  - functions deriving offset, index and tag widths from the parameters;
  - a line-base address helper.
- One sub-module, cpu_icache_refill: REFILL sequencer holding the issue and receive counters and the mem_* handshake. It reports done and the word write strobe plus slot to the parent.

Test Plan:
- Cold miss at 0x100, LINES=64, WORDS=4:
  - reads issued to 0x100, 0x104, 0x108, 0x10C;
  - p2_ack with p2_addr=0x100 after the last mem_valid plus 1;
  - miss_count=1.
- Sequential fetches 0x104, 0x108, 0x10C after the fill: p2_ack on 3 consecutive cycles with the matching words; hit_count=3.
- mem_busy held high 5 cycles on the 2nd request: mem_address stays 0x104 throughout; exactly 4 accepts; the line fills correctly.
- Conflict: fetch 0x100, then 0x1100 (same index, new tag), then 0x100: three misses, last data matches the original memory.
- Flush pulse after the fill, then fetch 0x100: miss. Flush mid-REFILL: replay delivers the word, but a refetch of 0x100 misses again.
- Reset low for 1 cycle mid-REFILL, with stale mem_valid afterwards:
  - state IDLE, busy=0, mem_request=0;
  - the stale response is ignored;
  - the next fetch of 0x100 misses.
